// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen and the pattern/colour stage.
// Optional test-bar colour ports exist only when VGA_TIMING_TESTBAR_EN is defined.
interface vga_timing_gen_if;
  logic       enable;
  logic       pix_tick;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       active;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_TIMING_TESTBAR_EN
  logic [7:0] tp_r;
  logic [7:0] tp_g;
  logic [7:0] tp_b;
`endif

  // Timing generator side
  modport master (
    input  enable,
    output pix_tick, VGA_HS, VGA_VS, VGA_BLANK_N, active,
    output pix_x, pix_y, line_start, frame_start
`ifdef VGA_TIMING_TESTBAR_EN
    , output tp_r, tp_g, tp_b
`endif
  );

  // Consumer side
  modport slave (
    output enable,
    input  pix_tick, VGA_HS, VGA_VS, VGA_BLANK_N, active,
    input  pix_x, pix_y, line_start, frame_start
`ifdef VGA_TIMING_TESTBAR_EN
    , input tp_r, tp_g, tp_b
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60 from a 50 MHz clock).
// Pixel-rate enable from a CLK_DIV divider; all outputs registered and decoded
// from next-state counter values so they move on the same edge as the counters.
// Optional: define VGA_TIMING_TESTBAR_EN for registered colour-bar outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SP       = (SYNC_POL != 0);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          tick;

  logic          hs_q, hs_d, vs_q, vs_d, act_q, act_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          tick_q, ls_q, ls_d, fs_q, fs_d;

  // Next-state counters: divider, then horizontal/vertical raster position
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    if (!vga.enable) begin
      tick  = 1'b0;
      div_d = '0;
      h_d   = H_LAST;
      v_d   = V_LAST;
    end
  end

  // Output decode from next-state position; disabled forces the idle values
  always_comb begin
    act_d = (h_d < H_ACT) && (v_d < V_ACT);
    hs_d  = ((h_d >= HS_BEG) && (h_d < HS_END)) ? SP : ~SP;
    vs_d  = ((v_d >= VS_BEG) && (v_d < VS_END)) ? SP : ~SP;
    x_d   = act_d ? h_d : '0;
    y_d   = act_d ? v_d : '0;
    ls_d  = tick && (h_d == '0);
    fs_d  = ls_d && (v_d == '0);
    if (!vga.enable) begin
      act_d = 1'b0;
      hs_d  = ~SP;
      vs_d  = ~SP;
      x_d   = '0;
      y_d   = '0;
    end
  end

  // Counter and output registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      h_q    <= H_LAST;
      v_q    <= V_LAST;
      hs_q   <= ~SP;
      vs_q   <= ~SP;
      act_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      tick_q <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      act_q  <= act_d;
      x_q    <= x_d;
      y_q    <= y_d;
      tick_q <= tick;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign vga.pix_tick    = tick_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = act_q;
  assign vga.active      = act_q;
  assign vga.pix_x       = x_q;
  assign vga.pix_y       = y_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;

`ifdef VGA_TIMING_TESTBAR_EN
  logic [3:0] bar;
  logic [7:0] r_q, g_q, b_q;

  assign bar = x_d[9:6];

  // Colour bars: 64-pixel bands, index bits select full R/G/B; black when blanked
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= (act_d && bar[0]) ? '1 : '0;
      g_q <= (act_d && bar[1]) ? '1 : '0;
      b_q <= (act_d && bar[2]) ? '1 : '0;
    end
  end

  assign vga.tp_r = r_q;
  assign vga.tp_g = g_q;
  assign vga.tp_b = b_q;
`endif

endmodule
